pgr_i2s_tx: RTL and testbench

PGR_I2S_TX -- requirements
Module: pgr_i2s_tx

---
 rtl/pgr_i2s_tx.sv | 157 +++++++++++++++
 tb/tb_pgr_i2s_tx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pgr_i2s_tx.sv
// I2S stereo transmitter: one-entry holding buffer feeding per-channel shift registers.
// Define PGR_I2S_TX_LEFT_JUSTIFIED_EN for left-justified framing instead of I2S one-bit delay.
module pgr_i2s_tx #(
   parameter int DATA_WIDTH = 16,
   parameter int SLOT_WIDTH = 16
) (
   input  logic                  sck,
   input  logic                  rst,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] l_data,
   input  logic [DATA_WIDTH-1:0] r_data,
   input  logic                  din_vld,
   output logic                  din_rdy,
   output logic                  ws,
   output logic                  sda,
   output logic                  busy,
   output logic                  underflow
);

   localparam int unsigned DW = DATA_WIDTH;
   localparam int unsigned SW = SLOT_WIDTH;
   localparam int unsigned CW = (SW > 1) ? $clog2(SW) : 1;
   localparam logic [CW-1:0] LAST = CW'(SW - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic            ws_q, ws_nxt;
   logic            sda_q, sda_nxt;
   logic            uf_q, uf_nxt;
   logic            full, full_nxt;
   logic [DW-1:0]   l_buf, r_buf;
   logic [DW-1:0]   l_sh, l_sh_nxt;
   logic [DW-1:0]   r_sh, r_sh_nxt;
   logic            slot_end_c;
   logic            frame_start_c;
   logic            accept_c;

   assign slot_end_c = (cnt == LAST);
   assign accept_c   = din_vld & ~full;

   // A frame starts from IDLE only with data ready; in RUN it repeats at the end of the right slot.
   always_comb begin
      frame_start_c = 1'b0;
      if (state == IDLE) frame_start_c = en & full;
      else               frame_start_c = slot_end_c & ws_q & en;
   end

   always_ff @(posedge sck) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (frame_start_c) state_nxt = RUN;
         RUN:  if (slot_end_c && ws_q && !en) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cnt_nxt  = cnt;
      ws_nxt   = ws_q;
      sda_nxt  = 1'b0;
      uf_nxt   = 1'b0;
      full_nxt = full;
      l_sh_nxt = l_sh;
      r_sh_nxt = r_sh;

      if (state == RUN) begin
         cnt_nxt = slot_end_c ? '0 : cnt + CW'(1);
         if (slot_end_c && !ws_q) ws_nxt = 1'b1;
`ifdef PGR_I2S_TX_LEFT_JUSTIFIED_EN
         // MSB leads in the ws-change cycle, so the right word starts at the left slot's last edge.
         if (slot_end_c && !ws_q) begin
            sda_nxt  = r_sh[DW-1];
            r_sh_nxt = {r_sh[DW-2:0], 1'b0};
         end else if (!slot_end_c && (32'(cnt) + 32'd1 < DW)) begin
            if (ws_q) begin
               sda_nxt  = r_sh[DW-1];
               r_sh_nxt = {r_sh[DW-2:0], 1'b0};
            end else begin
               sda_nxt  = l_sh[DW-1];
               l_sh_nxt = {l_sh[DW-2:0], 1'b0};
            end
         end
`else
         // One-bit delay: the bit shown at cnt=k+1 leaves the register at cnt=k, possibly past slot end.
         if (32'(cnt) < DW) begin
            if (ws_q) begin
               sda_nxt  = r_sh[DW-1];
               r_sh_nxt = {r_sh[DW-2:0], 1'b0};
            end else begin
               sda_nxt  = l_sh[DW-1];
               l_sh_nxt = {l_sh[DW-2:0], 1'b0};
            end
         end
`endif
      end

      if (frame_start_c) begin
         ws_nxt   = 1'b0;
         cnt_nxt  = '0;
         full_nxt = 1'b0;
         uf_nxt   = ~full;
`ifdef PGR_I2S_TX_LEFT_JUSTIFIED_EN
         sda_nxt  = full ? l_buf[DW-1] : 1'b0;
         l_sh_nxt = full ? {l_buf[DW-2:0], 1'b0} : '0;
`else
         l_sh_nxt = full ? l_buf : '0;
`endif
         r_sh_nxt = full ? r_buf : '0;
      end

      // Acceptance wins over the frame-start clear so an underflow-edge pair is kept.
      if (accept_c) full_nxt = 1'b1;
   end

   always_ff @(posedge sck) begin
      if (rst) begin
         cnt   <= '0;
         ws_q  <= 1'b1;
         sda_q <= 1'b0;
         uf_q  <= 1'b0;
         full  <= 1'b0;
         l_buf <= '0;
         r_buf <= '0;
         l_sh  <= '0;
         r_sh  <= '0;
      end else begin
         cnt   <= cnt_nxt;
         ws_q  <= ws_nxt;
         sda_q <= sda_nxt;
         uf_q  <= uf_nxt;
         full  <= full_nxt;
         l_sh  <= l_sh_nxt;
         r_sh  <= r_sh_nxt;
         if (accept_c) begin
            l_buf <= l_data;
            r_buf <= r_data;
         end
      end
   end

   assign din_rdy   = ~full;
   assign busy      = (state == RUN);
   assign ws        = ws_q;
   assign sda       = sda_q;
   assign underflow = uf_q;

endmodule

// File: tb/tb_pgr_i2s_tx.sv
// Bench for pgr_i2s_tx: directed frame sequence with random samples, checked against a
// per-slot bit-position model; a second instance covers a 32-cycle slot.
module tb_pgr_i2s_tx;

   localparam int DW  = 16;
   localparam int SW  = 16;
   localparam int SW2 = 32;
`ifdef PGR_I2S_TX_LEFT_JUSTIFIED_EN
   localparam bit LJ = 1'b1;
`else
   localparam bit LJ = 1'b0;
`endif

   logic          sck;
   logic          rst;
   logic          en, din_vld;
   logic [DW-1:0] l_data, r_data;
   logic          din_rdy, ws, sda, busy, underflow;
   logic          en2, vld2;
   logic [DW-1:0] l2, r2;
   logic          rdy2, ws2, sda2, busy2, uf2;

   int checks;
   int failures;

   pgr_i2s_tx #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW)) u_dut (
      .sck(sck), .rst(rst), .en(en), .l_data(l_data), .r_data(r_data),
      .din_vld(din_vld), .din_rdy(din_rdy), .ws(ws), .sda(sda),
      .busy(busy), .underflow(underflow)
   );

   pgr_i2s_tx #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW2)) u_dut32 (
      .sck(sck), .rst(rst), .en(en2), .l_data(l2), .r_data(r2),
      .din_vld(vld2), .din_rdy(rdy2), .ws(ws2), .sda(sda2),
      .busy(busy2), .underflow(uf2)
   );

   initial sck = 1'b0;
   always #5 sck = ~sck;

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge sck);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected sda at slot position k for a slot carrying word; prev is the previous slot's word.
   function automatic logic exp_bit(input logic [31:0] word, input logic [31:0] prev,
                                    input int k, input int sw);
      if (LJ) begin
         if (k < DW) return word[DW-1-k];
         return 1'b0;
      end
      if (k >= 1 && k <= DW) return word[DW-k];
      if (k == 0 && sw == DW) return prev[0];
      return 1'b0;
   endfunction

   // Walks one full frame from left cnt=0, optionally offering the next pair and dropping en.
   task automatic run_frame(input logic [31:0] l, input logic [31:0] r, input logic [31:0] prev,
                            input bit uf, input bit offer, input logic [31:0] nl,
                            input logic [31:0] nr, input int offer_at, input int drop_at);
      for (int k = 0; k < 2*SW; k++) begin
         int  slot;
         int  c;
         bit  acc;
         slot = k / SW;
         c    = k % SW;
         chk("ws", 32'(ws), 32'(slot));
         chk("sda", 32'(sda), 32'(exp_bit(slot != 0 ? r : l, slot != 0 ? l : prev, c, SW)));
         chk("busy", 32'(busy), 32'd1);
         chk("underflow", 32'(underflow), 32'(uf && k == 0));
         if (offer && k == offer_at) begin
            l_data  = DW'(nl);
            r_data  = DW'(nr);
            din_vld = 1'b1;
         end
         if (k == drop_at) en = 1'b0;
         acc = din_vld && din_rdy;
         step();
         if (acc) din_vld = 1'b0;
      end
   endtask

   initial begin
      logic [31:0] la, ra, bl, br, cl, cr, dl, dr, el, er, fl, fr, r2v;
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      en       = 1'b0;
      din_vld  = 1'b0;
      l_data   = '0;
      r_data   = '0;
      en2      = 1'b0;
      vld2     = 1'b0;
      l2       = '0;
      r2       = '0;
      step();
      step();
      chk("rst_ws", 32'(ws), 32'd1);
      chk("rst_sda", 32'(sda), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_uf", 32'(underflow), 32'd0);
      chk("rst_rdy", 32'(din_rdy), 32'd1);
      chk("rst_ws32", 32'(ws2), 32'd1);
      rst = 1'b0;
      step();

      // 32-cycle slot with a 16-bit all-ones left word
      r2v  = 32'($urandom) & 32'h0000_FFFF;
      l2   = 16'hFFFF;
      r2   = DW'(r2v);
      vld2 = 1'b1;
      en2  = 1'b1;
      step();
      vld2 = 1'b0;
      chk("w32_rdy", 32'(rdy2), 32'd0);
      step();
      en2 = 1'b0;
      for (int k = 0; k < 2*SW2; k++) begin
         int slot;
         slot = k / SW2;
         chk("w32_ws", 32'(ws2), 32'(slot));
         chk("w32_sda", 32'(sda2),
             32'(exp_bit(slot != 0 ? r2v : 32'h0000_FFFF, slot != 0 ? 32'h0000_FFFF : 32'd0,
                         k % SW2, SW2)));
         step();
      end
      chk("w32_idle_busy", 32'(busy2), 32'd0);
      chk("w32_idle_ws", 32'(ws2), 32'd1);
      chk("w32_idle_sda", 32'(sda2), 32'd0);

      // first frame from IDLE with the reference pair
      la = LJ ? 32'h0000_8001 : 32'h0000_A5C3;
      ra = 32'h0000_0F01;
      l_data  = DW'(la);
      r_data  = DW'(ra);
      din_vld = 1'b1;
      step();
      din_vld = 1'b0;
      chk("acc_rdy", 32'(din_rdy), 32'd0);
      chk("acc_idle", 32'(busy), 32'd0);
      en = 1'b1;
      step();
      chk("start_rdy", 32'(din_rdy), 32'd1);
      bl = 32'($urandom) & 32'h0000_FFFF;
      br = 32'($urandom) & 32'h0000_FFFF;
      run_frame(la, ra, 32'd0, 1'b0, 1'b1, bl, br, $urandom_range(1, 12), -1);
      cl = 32'($urandom) & 32'h0000_FFFF;
      cr = 32'($urandom) & 32'h0000_FFFF;
      run_frame(bl, br, ra, 1'b0, 1'b1, cl, cr, $urandom_range(1, 20), -1);
      // next pair arrives exactly on the underflowing frame-start edge
      dl = 32'($urandom) & 32'h0000_FFFF;
      dr = 32'($urandom) & 32'h0000_FFFF;
      run_frame(cl, cr, br, 1'b0, 1'b1, dl, dr, 2*SW-1, -1);
      chk("uf_hold_rdy", 32'(din_rdy), 32'd0);
      run_frame(32'd0, 32'd0, cr, 1'b1, 1'b0, 32'd0, 32'd0, -1, -1);
      run_frame(dl, dr, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, -1, $urandom_range(1, SW-2));
      chk("stop_busy", 32'(busy), 32'd0);
      chk("stop_ws", 32'(ws), 32'd1);
      chk("stop_rdy", 32'(din_rdy), 32'd1);
      chk("stop_tail", 32'(sda), 32'(exp_bit(dr, 32'd0, SW, SW)));
      step();
      chk("idle_sda", 32'(sda), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_uf", 32'(underflow), 32'd0);

      // reset mid left slot with a pair buffered
      el = 32'($urandom) & 32'h0000_FFFF;
      er = 32'($urandom) & 32'h0000_FFFF;
      l_data  = DW'(el);
      r_data  = DW'(er);
      din_vld = 1'b1;
      en      = 1'b1;
      step();
      din_vld = 1'b0;
      step();
      chk("mr_busy", 32'(busy), 32'd1);
      chk("mr_ws", 32'(ws), 32'd0);
      fl = 32'($urandom) & 32'h0000_FFFF;
      fr = 32'($urandom) & 32'h0000_FFFF;
      l_data  = DW'(fl);
      r_data  = DW'(fr);
      din_vld = 1'b1;
      step();
      din_vld = 1'b0;
      chk("mr_full", 32'(din_rdy), 32'd0);
      for (int i = 0; i < 4; i++) step();
      chk("mr_sda5", 32'(sda), 32'(exp_bit(el, 32'd0, 5, SW)));
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mr_ws_after", 32'(ws), 32'd1);
      chk("mr_sda_after", 32'(sda), 32'd0);
      chk("mr_rdy_after", 32'(din_rdy), 32'd1);
      chk("mr_busy_after", 32'(busy), 32'd0);
      chk("mr_uf_after", 32'(underflow), 32'd0);
      step();
      chk("mr_discard_busy", 32'(busy), 32'd0);
      chk("mr_discard_rdy", 32'(din_rdy), 32'd1);
      en = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
